// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// The serial line is synchronised, majority-voted over three samples and
// framed as start / data (LSB first) / optional parity / 1-2 stop bits.
// A finished frame and its status flags are held until the consumer takes it.
// Continuous low lines are reported as a break frame and then ignored until
// the line returns high.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 rx_serial_input,
  input  logic                 rx_ready,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_output,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  MID      = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic              ODD      = (PARITY_MODE == 2);
  localparam logic              LAST_STP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic [2:0]           hist_q;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 stop_err_q;
  logic                 first_stop_q;

  logic voted;
  logic complete;
  logic first_stop_now;
  logic frame_err_now;
  logic brk_now;

  // Two-flop synchroniser followed by a three-sample history for voting.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, giving a true shift register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx_serial_input};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign voted = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                 (hist_q[1] & hist_q[2]);

  // Per-frame results evaluated on the clock of the final stop sample.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    complete       = 1'b0;
    first_stop_now = first_stop_q;
    frame_err_now  = stop_err_q | ~voted;
    brk_now        = 1'b0;
    if (stop_idx == 1'b0) first_stop_now = voted;
    if (state == S_STOP && cnt == LAST && stop_idx == LAST_STP) complete = 1'b1;
    brk_now = (shift_q == '0) & ~first_stop_now;
  end

  // Receive FSM: bit timing, sampling, parity and stop-bit evaluation.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      stop_idx     <= 1'b0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      first_stop_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          stop_idx <= 1'b0;
          if (!sync_q[1]) state <= S_START;
        end
        S_START: begin
          if (cnt == MID) begin
            cnt   <= '0;
            state <= voted ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == LAST) begin
            cnt          <= '0;
            shift_q[idx] <= voted;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            par_err_q <= (^shift_q) ^ voted ^ ODD;
            state     <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (complete) begin
              stop_idx <= 1'b0;
              state    <= brk_now ? S_BREAK_WAIT : S_IDLE;
            end else begin
              stop_idx     <= 1'b1;
              stop_err_q   <= ~voted;
              first_stop_q <= voted;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK_WAIT: begin
          cnt <= '0;
          if (voted) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding registers: load on completion, release on a consumer handshake.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_data_valid <= 1'b0;
      rx_output     <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_break      <= 1'b0;
    end else if (complete) begin
      rx_data_valid <= 1'b1;
      rx_output     <= shift_q;
      rx_parity_err <= (PARITY_MODE != 0) ? par_err_q : 1'b0;
      rx_frame_err  <= frame_err_now | brk_now;
      rx_break      <= brk_now;
      rx_overrun    <= rx_data_valid & ~rx_ready;
    end else if (rx_data_valid && rx_ready) begin
      rx_data_valid <= 1'b0;
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule
